// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for the RV32 datapath. Each instruction is stepped
//   through FETCH / DECODE / EXEC / MEM / WB, talking to variable-latency
//   instruction and data memories over req/ack handshakes. A watchdog halts
//   the controller if a memory never acknowledges. An unknown opcode also
//   halts it. Cycle and retired-instruction counters are maintained.
//
// Parameters
//   CNT_W    width of cycle_cnt / instret_cnt
//   TMO_MAX  max wait cycles for an ack before halting (1..65535)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   opcode          instr[6:0] from the instruction register
//   zero            ALU zero flag, used by BEQ in EXEC
//   imem_ack        instruction memory data valid
//   dmem_ack        data memory access complete
//   imem_req        instruction fetch request
//   dmem_req        data memory request
//   dmem_we         data memory write (store)
//   ir_we           load instruction register
//   mdr_we          latch load data into the memory data register
//   regwr           register file write enable
//   alusrc          ALU operand B: 1 = immediate, 0 = rs2
//   memtoreg        writeback source: 1 = MDR, 0 = ALU result
//   aluop           00 add, 01 sub/compare, 10 funct-decoded
//   pc_we           update PC this cycle (also marks retirement)
//   pcsrc           PC source: 1 = branch target, 0 = PC+4
//   halted          controller is in HALT
//   err_code        00 none, 01 illegal opcode, 10 imem tmo, 11 dmem tmo
//   cycle_cnt       cycles since reset, excluding HALT
//   instret_cnt     retired instructions
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TMO_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             regwr,
  output logic             alusrc,
  output logic             memtoreg,
  output logic [1:0]       aluop,
  output logic             pc_we,
  output logic             pcsrc,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_I,
    C_LD,
    C_ST,
    C_BEQ
  } opclass_t;

  // The watchdog fires on the wait cycle that would bring the count to
  // TMO_MAX, so compare against TMO_MAX-1 before incrementing.
  localparam logic [15:0] TMO_LAST = 16'(TMO_MAX - 1);

  state_t           r_state;
  state_t           w_next;
  opclass_t         r_class;
  opclass_t         w_decClass;
  logic             w_decLegal;
  logic [15:0]      r_tmo;
  logic             w_tmoHit;
  logic [1:0]       r_err;
  logic [1:0]       w_nextErr;
  logic [CNT_W-1:0] r_cycleCnt;
  logic [CNT_W-1:0] r_instretCnt;

  assign w_tmoHit    = (r_tmo == TMO_LAST);
  assign err_code    = r_err;
  assign cycle_cnt   = r_cycleCnt;
  assign instret_cnt = r_instretCnt;

  // Opcode classifier; only consulted while in DECODE.
  always_comb begin
    w_decClass = C_R;
    w_decLegal = 1'b1;
    case (opcode)
      7'b0110011: w_decClass = C_R;
      7'b0010011: w_decClass = C_I;
      7'b0000011: w_decClass = C_LD;
      7'b0100011: w_decClass = C_ST;
      7'b1100011: w_decClass = C_BEQ;
      default:    w_decLegal = 1'b0;
    endcase
  end

  // Next-state and output decode. Outputs are Moore except ir_we, mdr_we,
  // pc_we and pcsrc, which depend on the same-cycle ack or zero. Reset
  // forces every control output low so an in-flight request is dropped.
  always_comb begin
    w_next    = r_state;
    w_nextErr = r_err;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    regwr     = 1'b0;
    alusrc    = 1'b0;
    memtoreg  = 1'b0;
    aluop     = 2'b00;
    pc_we     = 1'b0;
    pcsrc     = 1'b0;
    halted    = 1'b0;

    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_tmoHit) begin
          w_nextErr = 2'b10;
          w_next    = S_HALT;
        end
      end

      S_DECODE: begin
        if (w_decLegal) begin
          w_next = S_EXEC;
        end else begin
          w_nextErr = 2'b01;
          w_next    = S_HALT;
        end
      end

      S_EXEC: begin
        case (r_class)
          C_R: begin
            aluop  = 2'b10;
            w_next = S_WB;
          end
          C_I: begin
            aluop  = 2'b10;
            alusrc = 1'b1;
            w_next = S_WB;
          end
          C_LD, C_ST: begin
            alusrc = 1'b1;
            w_next = S_MEM;
          end
          C_BEQ: begin
            aluop  = 2'b01;
            pc_we  = 1'b1;
            pcsrc  = zero;
            w_next = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_class == C_ST);
        if (dmem_ack) begin
          if (r_class == C_ST) begin
            pc_we  = 1'b1;
            w_next = S_FETCH;
          end else begin
            mdr_we = 1'b1;
            w_next = S_WB;
          end
        end else if (w_tmoHit) begin
          w_nextErr = 2'b11;
          w_next    = S_HALT;
        end
      end

      S_WB: begin
        regwr    = 1'b1;
        memtoreg = (r_class == C_LD);
        pc_we    = 1'b1;
        w_next   = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: w_next = S_FETCH;
    endcase

    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      mdr_we   = 1'b0;
      regwr    = 1'b0;
      alusrc   = 1'b0;
      memtoreg = 1'b0;
      aluop    = 2'b00;
      pc_we    = 1'b0;
      pcsrc    = 1'b0;
      halted   = 1'b0;
    end
  end

  // State, op class, watchdog, error and performance counters. The
  // watchdog restarts whenever a waiting state (FETCH or MEM) is entered
  // and otherwise counts each cycle spent waiting without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_class      <= C_R;
      r_tmo        <= '0;
      r_err        <= 2'b00;
      r_cycleCnt   <= '0;
      r_instretCnt <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_nextErr;

      if (r_state == S_DECODE && w_decLegal) begin
        r_class <= w_decClass;
      end

      if (w_next != r_state && (w_next == S_FETCH || w_next == S_MEM)) begin
        r_tmo <= '0;
      end else if ((r_state == S_FETCH && !imem_ack) ||
                   (r_state == S_MEM   && !dmem_ack)) begin
        r_tmo <= r_tmo + 16'd1;
      end

      if (r_state != S_HALT) begin
        r_cycleCnt <= r_cycleCnt + CNT_W'(1);
      end

      if (pc_we) begin
        r_instretCnt <= r_instretCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl (TMO_MAX = 4). Inputs change on the
//   falling edge; outputs are sampled 1 ns later, well away from the rising
//   edge. Control outputs are packed into one vector per cycle:
//   {imem_req, dmem_req, dmem_we, ir_we, mdr_we, regwr, alusrc, memtoreg,
//    aluop[1:0], pc_we, pcsrc, halted}
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Common packed control patterns
  localparam logic [12:0] K_IDLE  = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] K_FWAIT = 13'b1_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] K_FACK  = 13'b1_0_0_1_0_0_0_0_00_0_0_0;
  localparam logic [12:0] K_HALT  = 13'b0_0_0_0_0_0_0_0_00_0_0_1;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        mdr_we;
  logic        regwr;
  logic        alusrc;
  logic        memtoreg;
  logic [1:0]  aluop;
  logic        pc_we;
  logic        pcsrc;
  logic        halted;
  logic [1:0]  err_code;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [12:0] ctl;

  int vectors;
  int miscompares;

  assign ctl = {imem_req, dmem_req, dmem_we, ir_we, mdr_we, regwr, alusrc,
                memtoreg, aluop, pc_we, pcsrc, halted};

  multicycle_ctrl #(.CNT_W(32), .TMO_MAX(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .mdr_we(mdr_we), .regwr(regwr), .alusrc(alusrc),
    .memtoreg(memtoreg), .aluop(aluop), .pc_we(pc_we), .pcsrc(pcsrc),
    .halted(halted), .err_code(err_code), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream wedges the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  // Pulse reset across one rising edge; starts and ends on a falling edge
  task automatic applyStimulus_reset();
    rst      = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    zero     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; opcode = OP_R;
    #1;
    vectors++;
    if (ctl !== K_IDLE) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl_pre got %b want %b", ctl, K_IDLE);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (ctl !== K_IDLE || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0 ||
        err_code !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_held ctl %b cyc %0d ret %0d err %b want %b 0 0 00",
               ctl, cycle_cnt, instret_cnt, err_code, K_IDLE);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (ctl !== K_FACK) begin
      miscompares++;
      $display("[TB] FAIL reset_fetch got %b want %b", ctl, K_FACK);
    end
  endtask

  task automatic test_rtype();
    logic [12:0] expv [4];
    expv[0] = K_FACK;
    expv[1] = K_IDLE;
    expv[2] = 13'b0_0_0_0_0_0_0_0_10_0_0_0;
    expv[3] = 13'b0_0_0_0_0_1_0_0_00_1_0_0;
    @(negedge clk);
    applyStimulus_reset();
    opcode = OP_R;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1;
      #1;
      vectors++;
      if (ctl !== expv[i]) begin
        miscompares++;
        $display("[TB] FAIL rtype_c%0d got %b want %b", i + 1, ctl, expv[i]);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (cycle_cnt !== 32'd4 || instret_cnt !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL rtype_cnt got cyc %0d ret %0d want 4 1", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_load_wait();
    logic [12:0] expv [8];
    expv[0] = K_FACK;
    expv[1] = K_IDLE;
    expv[2] = 13'b0_0_0_0_0_0_1_0_00_0_0_0;
    expv[3] = 13'b0_1_0_0_0_0_0_0_00_0_0_0;
    expv[4] = 13'b0_1_0_0_0_0_0_0_00_0_0_0;
    expv[5] = 13'b0_1_0_0_0_0_0_0_00_0_0_0;
    expv[6] = 13'b0_1_0_0_1_0_0_0_00_0_0_0;
    expv[7] = 13'b0_0_0_0_0_1_0_1_00_1_0_0;
    @(negedge clk);
    applyStimulus_reset();
    opcode = OP_LD;
    for (int i = 0; i < 8; i++) begin
      imem_ack = 1'b1;
      dmem_ack = (i == 6);
      #1;
      vectors++;
      if (ctl !== expv[i]) begin
        miscompares++;
        $display("[TB] FAIL load_c%0d got %b want %b", i + 1, ctl, expv[i]);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (cycle_cnt !== 32'd8 || instret_cnt !== 32'd1 || err_code !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL load_cnt got cyc %0d ret %0d err %b want 8 1 00",
               cycle_cnt, instret_cnt, err_code);
    end
  endtask

  task automatic test_beq();
    logic [12:0] expv [6];
    expv[0] = K_FACK;
    expv[1] = K_IDLE;
    expv[2] = 13'b0_0_0_0_0_0_0_0_01_1_1_0;
    expv[3] = K_FACK;
    expv[4] = K_IDLE;
    expv[5] = 13'b0_0_0_0_0_0_0_0_01_1_0_0;
    @(negedge clk);
    applyStimulus_reset();
    opcode = OP_BEQ;
    for (int i = 0; i < 6; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1;
      zero     = (i < 3);
      #1;
      vectors++;
      if (ctl !== expv[i]) begin
        miscompares++;
        $display("[TB] FAIL beq_c%0d got %b want %b", i + 1, ctl, expv[i]);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (cycle_cnt !== 32'd6 || instret_cnt !== 32'd2) begin
      miscompares++;
      $display("[TB] FAIL beq_cnt got cyc %0d ret %0d want 6 2", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] expv [8];
    expv[0] = K_FACK;
    expv[1] = K_IDLE;
    expv[2] = 13'b0_0_0_0_0_0_1_0_10_0_0_0;
    expv[3] = 13'b0_0_0_0_0_1_0_0_00_1_0_0;
    expv[4] = K_FACK;
    expv[5] = K_IDLE;
    expv[6] = 13'b0_0_0_0_0_0_1_0_00_0_0_0;
    expv[7] = 13'b0_1_1_0_0_0_0_0_00_1_0_0;
    @(negedge clk);
    applyStimulus_reset();
    for (int i = 0; i < 8; i++) begin
      opcode   = (i < 4) ? OP_I : OP_ST;
      imem_ack = 1'b1; dmem_ack = 1'b1;
      #1;
      vectors++;
      if (ctl !== expv[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_c%0d got %b want %b", i + 1, ctl, expv[i]);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (cycle_cnt !== 32'd8 || instret_cnt !== 32'd2) begin
      miscompares++;
      $display("[TB] FAIL b2b_cnt got cyc %0d ret %0d want 8 2", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    applyStimulus_reset();
    opcode = 7'b0000000;
    for (int i = 0; i < 12; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1;
      #1;
      vectors++;
      if (ctl !== ((i == 0) ? K_FACK : (i == 1) ? K_IDLE : K_HALT)) begin
        miscompares++;
        $display("[TB] FAIL illegal_c%0d got %b", i + 1, ctl);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (err_code !== 2'b01 || cycle_cnt !== 32'd2 || instret_cnt !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL illegal_state got err %b cyc %0d ret %0d want 01 2 0",
               err_code, cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_imem_timeout();
    @(negedge clk);
    applyStimulus_reset();
    opcode = OP_R;
    for (int i = 0; i < 6; i++) begin
      imem_ack = 1'b0;
      #1;
      vectors++;
      if (ctl !== ((i < 4) ? K_FWAIT : K_HALT)) begin
        miscompares++;
        $display("[TB] FAIL itmo_c%0d got %b", i + 1, ctl);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (err_code !== 2'b10 || cycle_cnt !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL itmo_state got err %b cyc %0d want 10 4", err_code, cycle_cnt);
    end
    // Ack on the last allowed wait cycle must win over the timeout
    applyStimulus_reset();
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      #1;
      vectors++;
      if (ctl !== ((i == 3) ? K_FACK : K_FWAIT)) begin
        miscompares++;
        $display("[TB] FAIL iack_c%0d got %b", i + 1, ctl);
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    #1;
    vectors++;
    if (ctl !== K_IDLE || err_code !== 2'b00 || cycle_cnt !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL iack_decode got ctl %b err %b cyc %0d want %b 00 4",
               ctl, err_code, cycle_cnt, K_IDLE);
    end
  endtask

  task automatic test_dmem_timeout();
    @(negedge clk);
    applyStimulus_reset();
    opcode = OP_LD;
    for (int i = 0; i < 8; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b0;
      #1;
      vectors++;
      if (i >= 3 && ctl !== ((i < 7) ? 13'b0_1_0_0_0_0_0_0_00_0_0_0 : K_HALT)) begin
        miscompares++;
        $display("[TB] FAIL dtmo_c%0d got %b", i + 1, ctl);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (err_code !== 2'b11 || cycle_cnt !== 32'd7 || instret_cnt !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL dtmo_state got err %b cyc %0d ret %0d want 11 7 0",
               err_code, cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_reset_mid_mem();
    @(negedge clk);
    applyStimulus_reset();
    opcode = OP_ST;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b0;
      @(negedge clk);
    end
    #1;
    vectors++;
    if (ctl !== 13'b0_1_1_0_0_0_0_0_00_0_0_0) begin
      miscompares++;
      $display("[TB] FAIL rmid_in_mem got %b", ctl);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ctl !== K_IDLE) begin
      miscompares++;
      $display("[TB] FAIL rmid_req_drop got %b want %b", ctl, K_IDLE);
    end
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b1;
    #1;
    vectors++;
    if (ctl !== K_FWAIT || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rmid_fetch got ctl %b cyc %0d ret %0d want %b 0 0",
               ctl, cycle_cnt, instret_cnt, K_FWAIT);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (ctl !== K_FWAIT || cycle_cnt !== 32'd1 || instret_cnt !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rmid_stray_ack got ctl %b cyc %0d ret %0d want %b 1 0",
               ctl, cycle_cnt, instret_cnt, K_FWAIT);
    end
    dmem_ack = 1'b0;
  endtask

  // Main sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    opcode   = OP_R;
    zero     = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load_wait();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
